// File: rtl/usb2_ext_bridge.sv
// usb2_ext_bridge: application-side companion of the USB2 protocol layer.
// Fill path: application byte stream -> EP1 (device->host) buffer, one full
// MAX_LEN packet at a time, handed to the host via ext_buf_in_ready.
// Drain path: EP2 (host->device) buffer -> application byte stream through a
// 2-entry skid buffer that absorbs the one-cycle buffer read latency.
// Optional feature macro: USB2_EXT_BRIDGE_CNT_EN adds fill_pkt_cnt/drain_pkt_cnt.
module usb2_ext_bridge #(
  parameter int MAX_LEN = 512,
  parameter int ADDR_W  = 9
) (
  input  logic              phy_clk,
  input  logic              reset_n,
  input  logic              ext_xfer_read,
  input  logic              ext_xfer_write,
  input  logic [9:0]        ext_xfer_len,
  output logic              ext_xfer_ready,
  output logic              ext_xfer_done,
  output logic [ADDR_W-1:0] ext_buf_in_addr,
  output logic [7:0]        ext_buf_in_data,
  output logic              ext_buf_in_wren,
  output logic              ext_buf_in_ready,
  output logic [ADDR_W-1:0] ext_buf_out_addr,
  input  logic [7:0]        ext_buf_out_q,
  output logic              ext_buf_out_ready,
  input  logic [7:0]        src_data,
  input  logic              src_valid,
  output logic              src_ready,
  output logic [7:0]        snk_data,
  output logic              snk_valid,
  input  logic              snk_ready,
  output logic              err_overrun
`ifdef USB2_EXT_BRIDGE_CNT_EN
  ,
  output logic [15:0]       fill_pkt_cnt,
  output logic [15:0]       drain_pkt_cnt
`endif
);

  localparam logic [9:0] MAX_LEN_C = 10'(MAX_LEN);

  typedef enum logic [1:0] {
    F_FILL = 2'd0,
    F_FULL = 2'd1,
    F_WAIT = 2'd2
  } fill_state_t;

  typedef enum logic {
    D_IDLE = 1'b0,
    D_RUN  = 1'b1
  } drain_state_t;

  // ---------------- fill path ----------------
  fill_state_t       fill_state_r;
  fill_state_t       fill_next_s;
  logic [9:0]        fill_cnt_r;
  logic              fill_hs_s;
  logic              src_ready_r;
  logic              in_wren_r;
  logic [ADDR_W-1:0] in_addr_r;
  logic [7:0]        in_data_r;
  logic              in_ready_r;

  assign fill_hs_s = src_valid & src_ready_r;

  // Fill FSM state register.
  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_state_r <= F_FILL;
    end else begin
      fill_state_r <= fill_next_s;
    end
  end

  // Fill FSM next state: packet length is always a full buffer.
  always_comb begin
    fill_next_s = fill_state_r;
    case (fill_state_r)
      F_FILL: begin
        if (fill_hs_s && (fill_cnt_r == (MAX_LEN_C - 10'd1))) begin
          fill_next_s = F_FULL;
        end else begin
          fill_next_s = F_FILL;
        end
      end
      F_FULL: begin
        if (ext_xfer_read) begin
          fill_next_s = F_WAIT;
        end else begin
          fill_next_s = F_FULL;
        end
      end
      F_WAIT: begin
        if (!ext_xfer_read) begin
          fill_next_s = F_FILL;
        end else begin
          fill_next_s = F_WAIT;
        end
      end
      default: fill_next_s = F_FILL;
    endcase
  end

  // Fill datapath: registered buffer writes, byte counter and host handshake flags.
  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_cnt_r  <= 10'd0;
      src_ready_r <= 1'b0;
      in_wren_r   <= 1'b0;
      in_addr_r   <= {ADDR_W{1'b0}};
      in_data_r   <= 8'h00;
      in_ready_r  <= 1'b0;
    end else begin
      src_ready_r <= (fill_next_s == F_FILL);
      in_wren_r   <= fill_hs_s;
      if (fill_hs_s) begin
        in_addr_r  <= fill_cnt_r[ADDR_W-1:0];
        in_data_r  <= src_data;
        fill_cnt_r <= fill_cnt_r + 10'd1;
      end else if ((fill_state_r == F_WAIT) && !ext_xfer_read) begin
        fill_cnt_r <= 10'd0;
      end
      case (fill_state_r)
        F_FILL:  in_ready_r <= 1'b0;
        F_FULL:  in_ready_r <= 1'b1;
        F_WAIT:  in_ready_r <= ext_xfer_read;
        default: in_ready_r <= 1'b0;
      endcase
    end
  end

  assign src_ready        = src_ready_r;
  assign ext_buf_in_wren  = in_wren_r;
  assign ext_buf_in_addr  = in_addr_r;
  assign ext_buf_in_data  = in_data_r;
  assign ext_buf_in_ready = in_ready_r;

  // ---------------- drain path ----------------
  drain_state_t drain_state_r;
  drain_state_t drain_next_s;
  logic [9:0]   eff_len_s;
  logic [9:0]   eff_len_r;
  logic [9:0]   issue_cnt_r;
  logic [9:0]   snk_cnt_r;
  logic         pend_r;
  logic [7:0]   skid_mem_r [0:1];
  logic         skid_wr_r;
  logic         skid_rd_r;
  logic [1:0]   skid_cnt_r;
  logic         pop_s;
  logic         start_s;
  logic         last_s;
  logic         issue_s;
  logic         done_r;
  logic         out_ready_r;
  logic         xfer_ready_r;
  logic         err_overrun_r;

  assign eff_len_s = ((ext_xfer_len == 10'd0) || (ext_xfer_len > MAX_LEN_C)) ? MAX_LEN_C : ext_xfer_len;

  // Drain control decode; a read is issued only when the skid buffer is
  // guaranteed a free slot when its data returns a cycle later.
  always_comb begin
    pop_s   = (skid_cnt_r != 2'd0) & snk_ready;
    start_s = (drain_state_r == D_IDLE) & ext_xfer_write;
    last_s  = (drain_state_r == D_RUN) & pop_s & ((snk_cnt_r + 10'd1) == eff_len_r);
    issue_s = (drain_state_r == D_RUN) & (issue_cnt_r != eff_len_r) &
              (({1'b0, skid_cnt_r} + {2'b00, pend_r}) <= (3'd1 + {2'b00, pop_s}));
  end

  // Drain FSM state register.
  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      drain_state_r <= D_IDLE;
    end else begin
      drain_state_r <= drain_next_s;
    end
  end

  // Drain FSM next state.
  always_comb begin
    drain_next_s = drain_state_r;
    case (drain_state_r)
      D_IDLE: begin
        if (start_s) begin
          drain_next_s = D_RUN;
        end else begin
          drain_next_s = D_IDLE;
        end
      end
      D_RUN: begin
        if (last_s) begin
          drain_next_s = D_IDLE;
        end else begin
          drain_next_s = D_RUN;
        end
      end
      default: drain_next_s = D_IDLE;
    endcase
  end

  // Drain datapath: length latch, read address, skid buffer and handshake flags.
  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      eff_len_r     <= 10'd0;
      issue_cnt_r   <= 10'd0;
      snk_cnt_r     <= 10'd0;
      pend_r        <= 1'b0;
      skid_mem_r[0] <= 8'h00;
      skid_mem_r[1] <= 8'h00;
      skid_wr_r     <= 1'b0;
      skid_rd_r     <= 1'b0;
      skid_cnt_r    <= 2'd0;
      done_r        <= 1'b0;
      out_ready_r   <= 1'b1;
      xfer_ready_r  <= 1'b1;
      err_overrun_r <= 1'b0;
    end else begin
      done_r <= last_s;
      pend_r <= issue_s;
      if ((drain_state_r == D_RUN) && ext_xfer_write) begin
        err_overrun_r <= 1'b1;
      end
      if (start_s) begin
        eff_len_r    <= eff_len_s;
        issue_cnt_r  <= 10'd0;
        snk_cnt_r    <= 10'd0;
        skid_wr_r    <= 1'b0;
        skid_rd_r    <= 1'b0;
        skid_cnt_r   <= 2'd0;
        out_ready_r  <= 1'b0;
        xfer_ready_r <= 1'b0;
      end else begin
        if (issue_s) begin
          issue_cnt_r <= issue_cnt_r + 10'd1;
        end
        if (pend_r) begin
          skid_mem_r[skid_wr_r] <= ext_buf_out_q;
          skid_wr_r             <= ~skid_wr_r;
        end
        if (pop_s) begin
          skid_rd_r <= ~skid_rd_r;
          snk_cnt_r <= snk_cnt_r + 10'd1;
        end
        skid_cnt_r <= skid_cnt_r + {1'b0, pend_r} - {1'b0, pop_s};
        if (last_s) begin
          out_ready_r  <= 1'b1;
          xfer_ready_r <= 1'b1;
        end
      end
    end
  end

  assign ext_buf_out_addr  = issue_cnt_r[ADDR_W-1:0];
  assign snk_data          = skid_mem_r[skid_rd_r];
  assign snk_valid         = (skid_cnt_r != 2'd0);
  assign ext_xfer_done     = done_r;
  assign ext_buf_out_ready = out_ready_r;
  assign ext_xfer_ready    = xfer_ready_r;
  assign err_overrun       = err_overrun_r;

`ifdef USB2_EXT_BRIDGE_CNT_EN
  logic [15:0] fill_pkt_cnt_r;
  logic [15:0] drain_pkt_cnt_r;

  // Completed-packet counters for both directions, wrapping at 16 bits.
  always_ff @(posedge phy_clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_pkt_cnt_r  <= 16'd0;
      drain_pkt_cnt_r <= 16'd0;
    end else begin
      if ((fill_state_r == F_FILL) && (fill_next_s == F_FULL)) begin
        fill_pkt_cnt_r <= fill_pkt_cnt_r + 16'd1;
      end
      if (last_s) begin
        drain_pkt_cnt_r <= drain_pkt_cnt_r + 16'd1;
      end
    end
  end

  assign fill_pkt_cnt  = fill_pkt_cnt_r;
  assign drain_pkt_cnt = drain_pkt_cnt_r;
`else
  // Packet counters not built in this configuration.
`endif

endmodule

// File: tb/tb_usb2_ext_bridge.sv
// Directed self-checking bench for usb2_ext_bridge.
module tb_usb2_ext_bridge;

  logic       phy_clk = 1'b0;
  logic       reset_n;
  logic       ext_xfer_read;
  logic       ext_xfer_write;
  logic [9:0] ext_xfer_len;
  logic       ext_xfer_ready;
  logic       ext_xfer_done;
  logic [8:0] ext_buf_in_addr;
  logic [7:0] ext_buf_in_data;
  logic       ext_buf_in_wren;
  logic       ext_buf_in_ready;
  logic [8:0] ext_buf_out_addr;
  logic [7:0] ext_buf_out_q;
  logic       ext_buf_out_ready;
  logic [7:0] src_data;
  logic       src_valid;
  logic       src_ready;
  logic [7:0] snk_data;
  logic       snk_valid;
  logic       snk_ready;
  logic       err_overrun;
`ifdef USB2_EXT_BRIDGE_CNT_EN
  logic [15:0] fill_pkt_cnt;
  logic [15:0] drain_pkt_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int fill_sent = 0;
  int fill_got = 0;
  logic [7:0] ep2_mem [0:511];

  usb2_ext_bridge #(.MAX_LEN(512), .ADDR_W(9)) dut (
    .phy_clk(phy_clk), .reset_n(reset_n),
    .ext_xfer_read(ext_xfer_read), .ext_xfer_write(ext_xfer_write), .ext_xfer_len(ext_xfer_len),
    .ext_xfer_ready(ext_xfer_ready), .ext_xfer_done(ext_xfer_done),
    .ext_buf_in_addr(ext_buf_in_addr), .ext_buf_in_data(ext_buf_in_data),
    .ext_buf_in_wren(ext_buf_in_wren), .ext_buf_in_ready(ext_buf_in_ready),
    .ext_buf_out_addr(ext_buf_out_addr), .ext_buf_out_q(ext_buf_out_q),
    .ext_buf_out_ready(ext_buf_out_ready),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
    .err_overrun(err_overrun)
`ifdef USB2_EXT_BRIDGE_CNT_EN
    , .fill_pkt_cnt(fill_pkt_cnt), .drain_pkt_cnt(drain_pkt_cnt)
`endif
  );

  always #5 phy_clk = ~phy_clk;

  // EP2 buffer model: synchronous read, data one cycle after address.
  always @(posedge phy_clk) ext_buf_out_q <= ep2_mem[ext_buf_out_addr];

  task automatic test_reset();
    reset_n = 1'b0; ext_xfer_read = 1'b0; ext_xfer_write = 1'b0; ext_xfer_len = 10'd0;
    src_data = 8'h00; src_valid = 1'b0; snk_ready = 1'b0;
    repeat (3) @(posedge phy_clk);
    #1;
    checks++; if (ext_buf_in_wren !== 1'b0) begin errors++; $display("FAIL rst_wren got %b exp 0", ext_buf_in_wren); end
    checks++; if (ext_buf_in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", ext_buf_in_ready); end
    checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL rst_src_ready got %b exp 0", src_ready); end
    checks++; if (ext_buf_out_ready !== 1'b1) begin errors++; $display("FAIL rst_out_ready got %b exp 1", ext_buf_out_ready); end
    checks++; if (ext_xfer_ready !== 1'b1) begin errors++; $display("FAIL rst_xfer_ready got %b exp 1", ext_xfer_ready); end
    checks++; if (ext_xfer_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", ext_xfer_done); end
    checks++; if (snk_valid !== 1'b0) begin errors++; $display("FAIL rst_snk_valid got %b exp 0", snk_valid); end
    checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got %b exp 0", err_overrun); end
    checks++; if (ext_buf_in_addr !== 9'd0) begin errors++; $display("FAIL rst_in_addr got %0d exp 0", ext_buf_in_addr); end
    checks++; if (ext_buf_out_addr !== 9'd0) begin errors++; $display("FAIL rst_out_addr got %0d exp 0", ext_buf_out_addr); end
    reset_n = 1'b1;
    @(posedge phy_clk); #1;
    checks++; if (src_ready !== 1'b1) begin errors++; $display("FAIL post_rst_src_ready got %b exp 1", src_ready); end
  endtask

  // Full-buffer fill with a 0x00..0xFF repeating source.
  task automatic test_fill();
    bit hs;
    fill_sent = 0; fill_got = 0; src_data = 8'h00; src_valid = 1'b1;
    for (int cyc = 0; cyc < 2000 && fill_got < 512; cyc++) begin
      hs = src_valid && src_ready;
      @(posedge phy_clk); #1;
      if (hs) begin fill_sent++; src_data = 8'(fill_sent); end
      if (ext_buf_in_wren === 1'b1) begin
        checks++; if (ext_buf_in_addr !== 9'(fill_got)) begin errors++; $display("FAIL fill_addr got %0d exp %0d", ext_buf_in_addr, fill_got); end
        checks++; if (ext_buf_in_data !== 8'(fill_got)) begin errors++; $display("FAIL fill_data got %0h exp %0h", ext_buf_in_data, 8'(fill_got)); end
        fill_got++;
        if (fill_got == 512) begin
          checks++; if (ext_buf_in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_early got %b exp 0", ext_buf_in_ready); end
        end
      end
    end
    checks++; if (fill_got != 512) begin errors++; $display("FAIL fill_count got %0d exp 512", fill_got); end
    @(posedge phy_clk); #1;
    checks++; if (ext_buf_in_ready !== 1'b1) begin errors++; $display("FAIL fill_in_ready got %b exp 1", ext_buf_in_ready); end
    checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL full_src_ready got %b exp 0", src_ready); end
    checks++; if (ext_buf_in_wren !== 1'b0) begin errors++; $display("FAIL full_wren got %b exp 0", ext_buf_in_wren); end
  endtask

  // Host read handshake, refill from address 0, read ignored while filling.
  task automatic test_read();
    bit hs;
    src_valid = 1'b0; ext_xfer_read = 1'b1;
    repeat (5) begin
      @(posedge phy_clk); #1;
      checks++; if (ext_buf_in_ready !== 1'b1) begin errors++; $display("FAIL read_in_ready got %b exp 1", ext_buf_in_ready); end
      checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL read_src_ready got %b exp 0", src_ready); end
    end
    ext_xfer_read = 1'b0;
    @(posedge phy_clk); #1;
    checks++; if (ext_buf_in_ready !== 1'b0) begin errors++; $display("FAIL fall_in_ready got %b exp 0", ext_buf_in_ready); end
    checks++; if (src_ready !== 1'b1) begin errors++; $display("FAIL fall_src_ready got %b exp 1", src_ready); end
    fill_sent = 0; fill_got = 0; src_data = 8'h00; src_valid = 1'b1;
    for (int cyc = 0; cyc < 50 && fill_got < 3; cyc++) begin
      hs = src_valid && src_ready;
      @(posedge phy_clk); #1;
      if (hs) begin fill_sent++; src_data = 8'(fill_sent); end
      src_valid = (fill_sent < 3);
      if (ext_buf_in_wren === 1'b1) begin
        checks++; if (ext_buf_in_addr !== 9'(fill_got)) begin errors++; $display("FAIL refill_addr got %0d exp %0d", ext_buf_in_addr, fill_got); end
        fill_got++;
      end
    end
    checks++; if (fill_got != 3) begin errors++; $display("FAIL refill_count got %0d exp 3", fill_got); end
    src_valid = 1'b0; ext_xfer_read = 1'b1;
    repeat (3) begin
      @(posedge phy_clk); #1;
      checks++; if (ext_buf_in_ready !== 1'b0) begin errors++; $display("FAIL fill_read_ready got %b exp 0", ext_buf_in_ready); end
      checks++; if (src_ready !== 1'b1) begin errors++; $display("FAIL fill_read_src got %b exp 1", src_ready); end
    end
    ext_xfer_read = 1'b0;
    @(posedge phy_clk); #1;
  endtask

  // One drain packet; rnd toggles snk_ready, ovr fires a second write mid-drain.
  task automatic do_drain(input logic [9:0] len, input int exp_n, input bit rnd, input bit ovr);
    bit hs;
    int got = 0;
    int done_cnt = 0;
    checks++; if (ext_xfer_ready !== 1'b1) begin errors++; $display("FAIL pre_xfer_ready got %b exp 1", ext_xfer_ready); end
    ext_xfer_len = len; ext_xfer_write = 1'b1; snk_ready = 1'b0;
    @(posedge phy_clk); #1;
    ext_xfer_write = 1'b0;
    checks++; if (ext_xfer_ready !== 1'b0) begin errors++; $display("FAIL start_xfer_ready got %b exp 0", ext_xfer_ready); end
    checks++; if (ext_buf_out_ready !== 1'b0) begin errors++; $display("FAIL start_out_ready got %b exp 0", ext_buf_out_ready); end
    for (int cyc = 0; cyc < 6000 && got < exp_n; cyc++) begin
      snk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      ext_xfer_len = 10'd8;
      ext_xfer_write = (ovr && cyc == 50);
      hs = (snk_valid === 1'b1) && snk_ready;
      if (hs) begin
        checks++; if (snk_data !== ep2_mem[got]) begin errors++; $display("FAIL drain_data idx %0d got %0h exp %0h", got, snk_data, ep2_mem[got]); end
        got++;
      end
      @(posedge phy_clk); #1;
      ext_xfer_write = 1'b0;
      checks++; if (ext_xfer_done !== (hs && got == exp_n)) begin errors++; $display("FAIL drain_done at %0d got %b", got, ext_xfer_done); end
      if (ext_xfer_done === 1'b1) done_cnt++;
    end
    snk_ready = 1'b1;
    repeat (2) begin
      @(posedge phy_clk); #1;
      if (ext_xfer_done === 1'b1) done_cnt++;
      checks++; if (snk_valid !== 1'b0) begin errors++; $display("FAIL drain_extra_valid got %b exp 0", snk_valid); end
    end
    checks++; if (got != exp_n) begin errors++; $display("FAIL drain_count got %0d exp %0d", got, exp_n); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL drain_done_cnt got %0d exp 1", done_cnt); end
    checks++; if (ext_buf_out_ready !== 1'b1) begin errors++; $display("FAIL end_out_ready got %b exp 1", ext_buf_out_ready); end
    checks++; if (ext_xfer_ready !== 1'b1) begin errors++; $display("FAIL end_xfer_ready got %b exp 1", ext_xfer_ready); end
    checks++; if (err_overrun !== ovr) begin errors++; $display("FAIL overrun got %b exp %b", err_overrun, ovr); end
  endtask

  task automatic test_drain_basic();
    do_drain(10'd64, 64, 1'b0, 1'b0);
  endtask

  task automatic test_drain_stall();
    do_drain(10'd64, 64, 1'b1, 1'b0);
  endtask

  task automatic test_drain_len();
    do_drain(10'd0, 512, 1'b0, 1'b0);
    do_drain(10'd700, 512, 1'b1, 1'b1);
  endtask

  // Reset asserted mid-fill (addr 200) with a stalled drain in flight.
  task automatic test_reset_mid();
    bit hs;
    bit hit = 1'b0;
    ext_xfer_len = 10'd64; ext_xfer_write = 1'b1; snk_ready = 1'b0;
    src_data = 8'(fill_sent); src_valid = 1'b1;
    for (int cyc = 0; cyc < 1000 && !hit; cyc++) begin
      hs = src_valid && src_ready;
      @(posedge phy_clk); #1;
      ext_xfer_write = 1'b0;
      if (hs) begin fill_sent++; src_data = 8'(fill_sent); end
      if (ext_buf_in_wren === 1'b1) begin
        checks++; if (ext_buf_in_addr !== 9'(fill_got)) begin errors++; $display("FAIL cont_addr got %0d exp %0d", ext_buf_in_addr, fill_got); end
        hit = (fill_got == 200);
        fill_got++;
      end
    end
    checks++; if (!hit) begin errors++; $display("FAIL mid_fill_reach got %0d exp 201", fill_got); end
    checks++; if (snk_valid !== 1'b1) begin errors++; $display("FAIL mid_drain_valid got %b exp 1", snk_valid); end
    reset_n = 1'b0;
    #1;
    checks++; if (ext_buf_in_wren !== 1'b0) begin errors++; $display("FAIL mid_rst_wren got %b exp 0", ext_buf_in_wren); end
    checks++; if (ext_buf_in_addr !== 9'd0) begin errors++; $display("FAIL mid_rst_in_addr got %0d exp 0", ext_buf_in_addr); end
    checks++; if (src_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_src_ready got %b exp 0", src_ready); end
    checks++; if (snk_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_snk_valid got %b exp 0", snk_valid); end
    checks++; if (ext_buf_out_addr !== 9'd0) begin errors++; $display("FAIL mid_rst_out_addr got %0d exp 0", ext_buf_out_addr); end
    checks++; if (ext_buf_out_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_out_ready got %b exp 1", ext_buf_out_ready); end
    checks++; if (ext_xfer_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_xfer_ready got %b exp 1", ext_xfer_ready); end
    checks++; if (err_overrun !== 1'b0) begin errors++; $display("FAIL mid_rst_overrun got %b exp 0", err_overrun); end
    @(posedge phy_clk); #1;
    reset_n = 1'b1;
    fill_sent = 0; fill_got = 0; src_data = 8'h00;
    for (int cyc = 0; cyc < 50 && fill_got < 2; cyc++) begin
      hs = src_valid && src_ready;
      @(posedge phy_clk); #1;
      if (hs) begin fill_sent++; src_data = 8'(fill_sent); end
      if (ext_buf_in_wren === 1'b1) begin
        checks++; if (ext_buf_in_addr !== 9'(fill_got)) begin errors++; $display("FAIL restart_addr got %0d exp %0d", ext_buf_in_addr, fill_got); end
        checks++; if (ext_buf_in_data !== 8'(fill_got)) begin errors++; $display("FAIL restart_data got %0h exp %0h", ext_buf_in_data, 8'(fill_got)); end
        fill_got++;
      end
    end
    checks++; if (fill_got != 2) begin errors++; $display("FAIL restart_count got %0d exp 2", fill_got); end
    src_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ep2_mem[i] = 8'((i * 7 + 3) % 256);
    test_reset();
    test_fill();
    test_read();
    test_drain_basic();
    test_drain_stall();
    test_drain_len();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
